// File: rtl/shift_pkg.sv
// Shared definitions for the burst shifter: shift/rotate mode codes and FSM state encoding.
package shift_pkg;

    localparam logic [1:0] MODE_SR  = 2'b00;
    localparam logic [1:0] MODE_SL  = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-step datapath: next register value and outgoing serial bits.
// Rotate modes exist only when ROTATE_EN is defined; otherwise they fall back to plain shifts.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic [STEP-1:0]  ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic [STEP-1:0]  ser_out
);

    logic              left;
    logic [STEP-1:0]   fill_r;
    logic [STEP-1:0]   fill_l;

    // mode[0] selects direction for both shift and rotate codes
    assign left = mode[0];

`ifdef ROTATE_EN
    assign fill_r = (mode == MODE_ROR) ? q[STEP-1:0] : ser_in;
    assign fill_l = (mode == MODE_ROL) ? q[WIDTH-1:WIDTH-STEP] : ser_in;
`else
    logic unused_mode_hi;
    assign unused_mode_hi = mode[1];
    assign fill_r = ser_in;
    assign fill_l = ser_in;
`endif

    assign q_next  = left ? {q[WIDTH-STEP-1:0], fill_l} : {fill_r, q[WIDTH-1:STEP]};
    assign ser_out = left ? q[WIDTH-1:WIDTH-STEP] : q[STEP-1:0];

endmodule

// File: rtl/param_burst_shifter.sv
// Burst shift engine: loads a word, then performs `count` STEP-bit shifts under start/busy/done.
// Build with ROTATE_EN defined to enable the rotate modes.
module param_burst_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load,
    input  logic             en,
    input  logic [STEP-1:0]  ser_in,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  ser_out,
    output logic             busy,
    output logic             done,
    output state_t           state
);

    // Handshake: start/load are sampled only in IDLE; busy is high for every RUN cycle
    // (stalled or not); done pulses for the single DONE cycle, after which IDLE accepts a new start.

    logic [1:0]       mode_r;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] q_next;

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .q       (q),
        .mode    (mode_r),
        .ser_in  (ser_in),
        .q_next  (q_next),
        .ser_out (ser_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            q         <= '0;
            mode_r    <= MODE_SR;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q         <= par_in;
                        mode_r    <= mode;
                        remaining <= count;
                        if (count != '0) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else if (load) begin
                        q <= par_in;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        q         <= q_next;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
